uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the UART RX engine. Accepts bytes over a
//  valid/ready stream, stores them in a circular FIFO and presents them to the MMIO register
//  block as a show-ahead read port. Reports level, sticky overrun and threshold interrupt.
//  Never back-pressures the engine: the line keeps receiving; bytes arriving when full are dropped.
// PARAMETERS
//  DEPTH          16   entries; power of 2, >= 2
//  DATA_W         8    byte width
//  THRESH         8    irq_level asserts when level >= THRESH; 1..DEPTH
//  TIMEOUT_TICKS  640  baud_x16 ticks of input silence before rx_timeout (4 frames x 10 bits x 16)
// PORTS
//  clk            in   1                 single clock
//  rst            in   1                 asynchronous, active-high reset
//  baud_x16_tick  in   1                 1-cycle pulse at 16x baud; used only with UART_RX_TIMEOUT_EN
//  rx_in_valid    in   1                 byte offered by RX engine
//  rx_in_ready    out  1                 constant 1 outside reset
//  rx_in_data     in   DATA_W            byte from RX engine
//  rd_valid       out  1                 FIFO non-empty
//  rd_data        out  DATA_W            head entry (show-ahead); undefined when !rd_valid
//  rd_pop         in   1                 1-cycle pop request from MMIO
//  ovr_clr        in   1                 clears sticky overrun
//  level          out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  overrun        out  1                 sticky: a byte was dropped
//  irq_level      out  1                 level >= THRESH
//  rx_timeout     out  1                 data waiting and input idle (feature-gated)
// BEHAVIOUR
//  Reset: wr_ptr/rd_ptr=0, level=0, rd_valid=0, overrun=0, irq_level=0, rx_timeout=0,
//   rx_in_ready=0 while rst is high; storage contents are not cleared.
//  Pointers are ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); empty: ptrs equal; full: MSBs differ, rest equal.
//  level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1); registered pointers, so all status is 1-cycle after event.
//  push = rx_in_valid (ready=1); write when !full, or when full AND pop_ok in the same cycle.
//  pop_ok = rd_pop && rd_valid; rd_pop on empty is ignored, with no side effects.
//  Full, push, no pop: byte dropped, pointers unchanged, overrun<=1 next cycle.
//  Full, push+pop: both happen, level stays DEPTH, no overrun.
//  Empty, push+pop: pop ignored, push stored, level 0->1.
//  Pointer wrap: natural binary rollover; no special case.
//  rd_data = mem[rd_ptr[ADDR_W-1:0]], combinational read; valid the cycle after a push lands.
//  overrun: ovr_clr and a drop in the same cycle -> overrun stays 1 (set wins).
//  Reset mid-operation: FIFO emptied immediately; any byte on rx_in_data that cycle is lost.
// CONFIGURATION
//  `UART_RX_TIMEOUT_EN defined: 16-bit idle counter. Cleared on push, on pop_ok, and while empty.
//   Otherwise it increments on baud_x16_tick, saturating at TIMEOUT_TICKS.
//   rx_timeout = (count == TIMEOUT_TICKS) && rd_valid; drops the cycle after the next push or pop.
//  Undefined: no counter; rx_timeout tied 0; baud_x16_tick unused.
// STRUCTURE
//  uart_pkg: UART_DATA_W, frame tick constant (16 ticks x 10 bits), default depth/threshold.
//  Sub-module uart_fifo_mem: DEPTH x DATA_W storage with one write port and one async read port.
//  uart_rx_fifo owns the pointers, flags and timeout counter.
// TESTING
//  1 Reset, then push 0xA5 -> rd_valid=1, rd_data=0xA5 and level=1 next cycle; pop -> level=0, rd_valid=0.
//  2 Push 16 bytes 0x00..0x0F (DEPTH=16) -> level=16, irq_level from 8th byte; 17th push 0x55 -> overrun=1.
//    Pops then return 0x00..0x0F in order; 0x55 is never seen.
//  3 Full FIFO, push 0x77 and pop in the same cycle -> level stays 16, overrun=0, 0x77 read last.
//  4 Repeated push/pop across 40 bytes (pointer wrap) -> data order preserved; rd_pop on empty -> level 0.
//  5 Drop and ovr_clr in the same cycle -> overrun=1; ovr_clr alone -> 0.
//  6 (TIMEOUT_EN) One byte, then 640 ticks -> rx_timeout=1 on the 640th tick; pop -> 0.
//    Without the macro -> rx_timeout stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, frame timing in 16x baud ticks, and the
// default receive-FIFO sizing.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int UART_TICKS_PER_BIT   = 16;
    localparam int UART_BITS_PER_FRAME  = 10;
    localparam int UART_FRAME_TICKS     = UART_TICKS_PER_BIT * UART_BITS_PER_FRAME;
    localparam int UART_DEFAULT_DEPTH   = 16;
    localparam int UART_DEFAULT_THRESH  = 8;
    localparam int UART_DEFAULT_TIMEOUT = 4 * UART_FRAME_TICKS;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_DEFAULT_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: never back-pressures the RX engine, show-ahead read port,
// sticky overrun and level interrupt. Define UART_RX_TIMEOUT_EN for the idle timeout.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH         = UART_DEFAULT_DEPTH,
    parameter int DATA_W        = UART_DATA_W,
    parameter int THRESH        = UART_DEFAULT_THRESH,
    parameter int TIMEOUT_TICKS = UART_DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_x16_tick,
    input  logic                     rx_in_valid,
    output logic                     rx_in_ready,
    input  logic [DATA_W-1:0]        rx_in_data,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_pop,
    input  logic                     ovr_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic                     irq_level,
    output logic                     rx_timeout
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam logic [LVL_W-1:0] THRESH_LVL = LVL_W'(THRESH);

    logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ovr_q, ovr_d;
    logic             empty, full, pop_ok, wr_en, drop;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}});
    assign pop_ok = rd_pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en  = rx_in_valid && (!full || pop_ok);
    assign drop   = rx_in_valid && full && !pop_ok;

    always_comb begin
        wr_ptr_d = wr_en  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovr_d    = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (rx_in_data),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign rx_in_ready = !rst;
    assign rd_valid    = !empty;
    assign level       = wr_ptr_q - rd_ptr_q;
    assign overrun     = ovr_q;
    assign irq_level   = (level >= THRESH_LVL);

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_TICKS);

    logic [15:0] idle_q, idle_d;

    // Any line activity (even a dropped byte) or a read restarts the idle window.
    always_comb begin
        idle_d = idle_q;
        if (empty || rx_in_valid || pop_ok) begin
            idle_d = '0;
        end else if (baud_x16_tick && (idle_q != TIMEOUT_CNT)) begin
            idle_d = idle_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign rx_timeout = (idle_q == TIMEOUT_CNT) && rd_valid;
`else
    localparam int unused_timeout_ticks = TIMEOUT_TICKS;
    logic unused_tick;

    assign unused_tick = baud_x16_tick;
    assign rx_timeout  = 1'b0;
`endif

endmodule
